// File: rtl/rt_jtag_pkg.sv
// Shared TAP state encoding, opcodes and the IEEE 1149.1 next-state rule.
package rt_jtag_pkg;

   typedef enum logic [3:0] {
      EXIT2_DR = 4'h0,
      EXIT1_DR = 4'h1,
      SHIFT_DR = 4'h2,
      PAUSE_DR = 4'h3,
      SEL_IR   = 4'h4,
      UPD_DR   = 4'h5,
      CAP_DR   = 4'h6,
      SEL_DR   = 4'h7,
      EXIT2_IR = 4'h8,
      EXIT1_IR = 4'h9,
      SHIFT_IR = 4'hA,
      PAUSE_IR = 4'hB,
      RTI      = 4'hC,
      UPD_IR   = 4'hD,
      CAP_IR   = 4'hE,
      TLR      = 4'hF
   } tap_state_e;

   localparam logic [4:0] IR_IDCODE    = 5'h01;
   localparam logic [4:0] IR_USER      = 5'h10;
   localparam logic [4:0] IR_BYPASS    = 5'h1F;
   localparam logic [4:0] IrCaptureVal = 5'b00001;

   // TMS-driven transition of the 16-state TAP controller
   function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
      case (s)
         TLR:      return tms ? TLR      : RTI;
         RTI:      return tms ? SEL_DR   : RTI;
         SEL_DR:   return tms ? SEL_IR   : CAP_DR;
         CAP_DR:   return tms ? EXIT1_DR : SHIFT_DR;
         SHIFT_DR: return tms ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR: return tms ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: return tms ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR: return tms ? UPD_DR   : SHIFT_DR;
         UPD_DR:   return tms ? SEL_DR   : RTI;
         SEL_IR:   return tms ? TLR      : CAP_IR;
         CAP_IR:   return tms ? EXIT1_IR : SHIFT_IR;
         SHIFT_IR: return tms ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR: return tms ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: return tms ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR: return tms ? UPD_IR   : SHIFT_IR;
         UPD_IR:   return tms ? SEL_DR   : RTI;
         default:  return TLR;
      endcase
   endfunction

endpackage

// File: rtl/rt_jtag_sync_edge.sv
// Synchroniser for the JTAG pins; edge_i additionally yields registered rise/fall strobes.
module rt_jtag_sync_edge #(
   parameter int unsigned      Width      = 1,
   parameter int unsigned      SyncStages = 2,
   parameter logic [Width-1:0] ResetVal   = '0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             edge_i,
   input  logic [Width-1:0] level_i,
   output logic             rise_o,
   output logic             fall_o,
   output logic [Width-1:0] level_o
);

   localparam int unsigned ChainWidth = Width + 1;

   logic [ChainWidth-1:0] sync_q [SyncStages];
   logic                  edge_prev_q;
   logic                  edge_s;

   assign edge_s  = sync_q[SyncStages-1][0];
   assign level_o = sync_q[SyncStages-1][ChainWidth-1:1];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < SyncStages; i++) begin
            sync_q[i] <= {ResetVal, 1'b0};
         end
         edge_prev_q <= 1'b0;
         rise_o      <= 1'b0;
         fall_o      <= 1'b0;
      end else begin
         sync_q[0] <= {level_i, edge_i};
         for (int unsigned i = 1; i < SyncStages; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         edge_prev_q <= edge_s;
         rise_o      <= edge_s & ~edge_prev_q;
         fall_o      <= ~edge_s & edge_prev_q;
      end
   end

endmodule

// File: rtl/rt_jtag_tap_sampled.sv
// JTAG TAP responder on an oversampled TCK: IDCODE, BYPASS and a USER DR
// with a parallel read/write port into the fabric.
module rt_jtag_tap_sampled
   import rt_jtag_pkg::*;
#(
   parameter int unsigned IrLength    = 5,
   parameter logic [31:0] IdCode      = 32'h1000_0DB3,
   parameter int unsigned UserDrWidth = 32,
   parameter int unsigned SyncStages  = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   jtag_tck_i,
   input  logic                   jtag_tms_i,
   input  logic                   jtag_trst_ni,
   input  logic                   jtag_td_i,
   output logic                   jtag_td_o,
   output logic                   jtag_td_oe_o,
   input  logic [UserDrWidth-1:0] user_rdata_i,
   output logic [UserDrWidth-1:0] user_wdata_o,
   output logic                   user_wvalid_o,
   output logic [3:0]             tap_state_o
);

   localparam int unsigned         IdWidth   = 32;
   localparam logic [IrLength-1:0] OpIdcode  = IrLength'(IR_IDCODE);
   localparam logic [IrLength-1:0] OpUser    = IrLength'(IR_USER);
   localparam logic [IrLength-1:0] OpCapture = IrLength'(IrCaptureVal);

   logic                   tck_rise, tck_fall;
   logic [2:0]             pin_lvl;
   logic                   tms_s, tdi_s, trst_ns;
   tap_state_e             state_q, state_nxt;
   logic [IrLength-1:0]    ir_q, ir_shift_q;
   logic [IdWidth-1:0]     id_shift_q;
   logic [UserDrWidth-1:0] user_shift_q;
   logic                   bypass_q;
   logic                   sel_id, sel_user, dr_lsb;

   rt_jtag_sync_edge #(
      .Width      (3),
      .SyncStages (SyncStages),
      .ResetVal   (3'b100)
   ) u_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .edge_i  (jtag_tck_i),
      .level_i ({jtag_trst_ni, jtag_td_i, jtag_tms_i}),
      .rise_o  (tck_rise),
      .fall_o  (tck_fall),
      .level_o (pin_lvl)
   );

   assign tms_s   = pin_lvl[0];
   assign tdi_s   = pin_lvl[1];
   assign trst_ns = pin_lvl[2];

   // Unknown opcodes fall through to BYPASS
   assign sel_id      = (ir_q == OpIdcode);
   assign sel_user    = (ir_q == OpUser);
   assign dr_lsb      = sel_user ? user_shift_q[0] : (sel_id ? id_shift_q[0] : bypass_q);
   assign state_nxt   = tap_next(state_q, tms_s);
   assign tap_state_o = state_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= TLR;
         ir_q          <= OpIdcode;
         ir_shift_q    <= '0;
         id_shift_q    <= '0;
         user_shift_q  <= '0;
         bypass_q      <= 1'b0;
         jtag_td_o     <= 1'b0;
         jtag_td_oe_o  <= 1'b0;
         user_wdata_o  <= '0;
         user_wvalid_o <= 1'b0;
      end else if (!trst_ns) begin
         // TRST outranks a coincident tck_rise: no shift, update or pulse
         state_q       <= TLR;
         ir_q          <= OpIdcode;
         jtag_td_o     <= 1'b0;
         jtag_td_oe_o  <= 1'b0;
         user_wvalid_o <= 1'b0;
      end else begin
         user_wvalid_o <= 1'b0;
         if (tck_rise) begin
            case (state_q)
               CAP_IR:   ir_shift_q <= OpCapture;
               SHIFT_IR: ir_shift_q <= {tdi_s, ir_shift_q[IrLength-1:1]};
               UPD_IR:   ir_q       <= ir_shift_q;
               CAP_DR: begin
                  if (sel_user)    user_shift_q <= user_rdata_i;
                  else if (sel_id) id_shift_q   <= IdCode;
                  else             bypass_q     <= 1'b0;
               end
               SHIFT_DR: begin
                  if (sel_user)    user_shift_q <= {tdi_s, user_shift_q[UserDrWidth-1:1]};
                  else if (sel_id) id_shift_q   <= {tdi_s, id_shift_q[IdWidth-1:1]};
                  else             bypass_q     <= tdi_s;
               end
               UPD_DR: begin
                  if (sel_user) begin
                     user_wdata_o  <= user_shift_q;
                     user_wvalid_o <= 1'b1;
                  end
               end
               default: ;
            endcase
            state_q <= state_nxt;
            if (state_nxt == TLR) ir_q <= OpIdcode;
         end
         if (tck_fall) begin
            jtag_td_oe_o <= (state_q == SHIFT_IR) || (state_q == SHIFT_DR);
            case (state_q)
               SHIFT_IR: jtag_td_o <= ir_shift_q[0];
               SHIFT_DR: jtag_td_o <= dr_lsb;
               default:  jtag_td_o <= 1'b0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rt_jtag_tap_sampled.sv
// Bench for rt_jtag_tap_sampled: directed and random TCK-level traffic checked
// against a queue-based TAP model, plus literal expectations from the test plan.
module tb_rt_jtag_tap_sampled;
   import rt_jtag_pkg::*;

   localparam int unsigned SyncStages = 2;
   localparam logic [31:0] IdCode     = 32'h1000_0DB3;
   localparam int unsigned PhaseClks  = 6;

   logic        clk = 1'b0;
   logic        rst, tck, tms, trst_n, tdi;
   logic        td, td_oe, wvalid;
   logic [31:0] rdata, wdata;
   logic [3:0]  tap_state;

   always #5 clk = ~clk;

   rt_jtag_tap_sampled #(
      .IrLength    (5),
      .IdCode      (IdCode),
      .UserDrWidth (32),
      .SyncStages  (SyncStages)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .jtag_tck_i    (tck),
      .jtag_tms_i    (tms),
      .jtag_trst_ni  (trst_n),
      .jtag_td_i     (tdi),
      .jtag_td_o     (td),
      .jtag_td_oe_o  (td_oe),
      .user_rdata_i  (rdata),
      .user_wdata_o  (wdata),
      .user_wvalid_o (wvalid),
      .tap_state_o   (tap_state)
   );

   int checks = 0;
   int passes = 0;
   int pulse_cnt = 0;
   int long_pulses = 0;
   logic wv_prev = 1'b0;

   // Count write pulses and flag any that last longer than one cycle
   always @(negedge clk) begin
      if (wvalid === 1'b1) begin
         pulse_cnt <= pulse_cnt + 1;
         if (wv_prev === 1'b1) long_pulses <= long_pulses + 1;
      end
      wv_prev <= wvalid;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   // Behavioural model, advanced once per TCK cycle
   tap_state_e  m_state;
   logic [4:0]  m_ir;
   logic [31:0] m_wdata;
   int          m_pulses;
   bit          m_irq[$];
   bit          m_drq[$];

   function automatic tap_state_e model_next(input tap_state_e s, input logic t_ms);
      case (s)
         TLR:                 return t_ms ? TLR : RTI;
         RTI, UPD_DR, UPD_IR: return t_ms ? SEL_DR : RTI;
         SEL_DR:              return t_ms ? SEL_IR : CAP_DR;
         SEL_IR:              return t_ms ? TLR : CAP_IR;
         CAP_DR, SHIFT_DR:    return t_ms ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR:            return t_ms ? UPD_DR : PAUSE_DR;
         PAUSE_DR:            return t_ms ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR:            return t_ms ? UPD_DR : SHIFT_DR;
         CAP_IR, SHIFT_IR:    return t_ms ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR:            return t_ms ? UPD_IR : PAUSE_IR;
         PAUSE_IR:            return t_ms ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR:            return t_ms ? UPD_IR : SHIFT_IR;
         default:             return TLR;
      endcase
   endfunction

   function automatic logic [31:0] q_val(input bit q[$]);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < q.size() && i < 32; i++) v[i] = q[i];
      return v;
   endfunction

   task automatic model_rise(input logic t_ms, input logic t_di);
      case (m_state)
         CAP_IR: begin
            m_irq.delete();
            for (int i = 0; i < 5; i++) m_irq.push_back(i == 0);
         end
         SHIFT_IR: begin
            void'(m_irq.pop_front());
            m_irq.push_back(t_di);
         end
         UPD_IR: m_ir = 5'(q_val(m_irq));
         CAP_DR: begin
            m_drq.delete();
            if (m_ir == 5'h01)      for (int i = 0; i < 32; i++) m_drq.push_back(IdCode[i]);
            else if (m_ir == 5'h10) for (int i = 0; i < 32; i++) m_drq.push_back(rdata[i]);
            else                    m_drq.push_back(1'b0);
         end
         SHIFT_DR: begin
            void'(m_drq.pop_front());
            m_drq.push_back(t_di);
         end
         UPD_DR: begin
            if (m_ir == 5'h10) begin
               m_wdata = q_val(m_drq);
               m_pulses++;
            end
         end
         default: ;
      endcase
      m_state = model_next(m_state, t_ms);
      if (m_state == TLR) m_ir = 5'h01;
   endtask

   task automatic check_outputs();
      logic exp_td;
      exp_td = 1'b0;
      if (m_state == SHIFT_IR)      exp_td = m_irq[0];
      else if (m_state == SHIFT_DR) exp_td = m_drq[0];
      check("tap_state", 32'(tap_state), 32'(m_state));
      check("td_oe", 32'(td_oe), 32'((m_state == SHIFT_IR) || (m_state == SHIFT_DR)));
      check("td_o", 32'(td), 32'(exp_td));
      check("user_wdata", wdata, m_wdata);
      check("wvalid_pulses", 32'(pulse_cnt), 32'(m_pulses));
   endtask

   // One TCK period; TDO is sampled at the end of the low phase, just before the next rise
   task automatic tck_cycle(input logic t_ms, input logic t_di, output logic t_do);
      @(negedge clk);
      tms = t_ms;
      tdi = t_di;
      @(negedge clk);
      tck = 1'b1;
      repeat (PhaseClks) @(negedge clk);
      tck = 1'b0;
      repeat (PhaseClks) @(negedge clk);
      model_rise(t_ms, t_di);
      t_do = td;
      check_outputs();
   endtask

   task automatic ir_scan(input logic [4:0] op, output logic [4:0] cap);
      logic d;
      tck_cycle(1'b1, 1'b0, d);
      tck_cycle(1'b1, 1'b0, d);
      tck_cycle(1'b0, 1'b0, d);
      tck_cycle(1'b0, 1'b0, d);
      cap[0] = d;
      for (int i = 0; i < 5; i++) begin
         tck_cycle(i == 4, op[i], d);
         if (i < 4) cap[i+1] = d;
      end
      tck_cycle(1'b1, 1'b0, d);
      tck_cycle(1'b0, 1'b0, d);
   endtask

   // From RTI: shift n bits and return to RTI, or stop in Pause-DR
   task automatic dr_scan(input int n, input logic [63:0] din, input bit to_pause,
                          output logic [63:0] dout);
      logic d;
      dout = '0;
      tck_cycle(1'b1, 1'b0, d);
      tck_cycle(1'b0, 1'b0, d);
      tck_cycle(1'b0, 1'b0, d);
      dout[0] = d;
      for (int i = 0; i < n; i++) begin
         tck_cycle(i == n - 1, din[i], d);
         if (i < n - 1) dout[i+1] = d;
      end
      if (to_pause) begin
         tck_cycle(1'b0, 1'b0, d);
      end else begin
         tck_cycle(1'b1, 1'b0, d);
         tck_cycle(1'b0, 1'b0, d);
      end
   endtask

   task automatic to_rti();
      logic d;
      for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, d);
      tck_cycle(1'b0, 1'b0, d);
   endtask

   logic        d;
   logic [4:0]  cap, op;
   logic [63:0] dout;
   int          pc0;

   initial begin
      rst = 1'b1; tck = 1'b0; tms = 1'b1; trst_n = 1'b1; tdi = 1'b0; rdata = '0;
      m_state = TLR; m_ir = 5'h01; m_wdata = '0; m_pulses = 0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_state", 32'(tap_state), 32'(TLR));
      check("reset_td_oe", 32'(td_oe), 32'd0);
      check("reset_td_o", 32'(td), 32'd0);
      check("reset_wvalid", 32'(wvalid), 32'd0);
      check("reset_wdata", wdata, 32'd0);

      // IDCODE selected out of reset
      tck_cycle(1'b0, 1'b0, d);
      dr_scan(32, 64'd0, 1'b0, dout);
      check("idcode_stream", dout[31:0], 32'h1000_0DB3);

      // BYPASS: one-bit delay with captured 0 first
      ir_scan(5'h1F, cap);
      check("ir_capture", 32'(cap), 32'h01);
      dr_scan(4, 64'b1101, 1'b0, dout);
      check("bypass_stream", 32'(dout[3:0]), 32'b1010);

      // USER read/write
      rdata = 32'hCAFE_F00D;
      ir_scan(5'h10, cap);
      pc0 = pulse_cnt;
      dr_scan(32, 64'hDEAD_BEEF, 1'b0, dout);
      check("user_read", dout[31:0], 32'hCAFE_F00D);
      check("user_write", wdata, 32'hDEAD_BEEF);
      check("user_one_pulse", 32'(pulse_cnt - pc0), 32'd1);

      // Over-long USER shift keeps the last 32 bits
      dr_scan(40, 64'h0000_00A5_1234_5678, 1'b0, dout);
      check("user_long_write", wdata, 32'hA512_3456);

      // Pause-DR then TMS high for five TCKs reaches TLR and restores IDCODE
      ir_scan(5'h1F, cap);
      dr_scan(3, 64'b101, 1'b1, dout);
      for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, d);
      check("pause_to_tlr", 32'(tap_state), 32'(TLR));
      tck_cycle(1'b0, 1'b0, d);
      dr_scan(32, 64'd0, 1'b0, dout);
      check("idcode_after_tlr", dout[31:0], 32'h1000_0DB3);
      ir_scan(5'h07, cap);
      dr_scan(4, 64'b1101, 1'b0, dout);
      check("unknown_op_bypass", 32'(dout[3:0]), 32'b1010);

      // TRST mid USER shift
      rdata = $urandom;
      ir_scan(5'h10, cap);
      pc0 = pulse_cnt;
      tck_cycle(1'b1, 1'b0, d);
      tck_cycle(1'b0, 1'b0, d);
      tck_cycle(1'b0, 1'b0, d);
      for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'($urandom_range(0, 1)), d);
      @(negedge clk);
      trst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      trst_n = 1'b1;
      @(negedge clk);
      check("trst_state", 32'(tap_state), 32'(TLR));
      check("trst_td_oe", 32'(td_oe), 32'd0);
      check("trst_wdata_kept", wdata, 32'hA512_3456);
      m_state = TLR; m_ir = 5'h01;
      repeat (4) @(negedge clk);
      check("trst_no_pulse", 32'(pulse_cnt - pc0), 32'd0);
      tck_cycle(1'b0, 1'b0, d);

      // rst_i mid USER shift
      ir_scan(5'h10, cap);
      pc0 = pulse_cnt;
      tck_cycle(1'b1, 1'b0, d);
      tck_cycle(1'b0, 1'b0, d);
      tck_cycle(1'b0, 1'b0, d);
      for (int i = 0; i < 6; i++) tck_cycle(1'b0, 1'($urandom_range(0, 1)), d);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      m_state = TLR; m_ir = 5'h01; m_wdata = '0;
      check("rst_state", 32'(tap_state), 32'(TLR));
      check("rst_wdata", wdata, 32'd0);
      repeat (4) @(negedge clk);
      check("rst_no_pulse", 32'(pulse_cnt - pc0), 32'd0);
      tck_cycle(1'b0, 1'b0, d);

      // Randomised traffic against the model
      for (int it = 0; it < 30; it++) begin
         case ($urandom_range(0, 3))
            0: begin
               case ($urandom_range(0, 4))
                  0:       op = 5'h01;
                  1:       op = 5'h10;
                  2:       op = 5'h1F;
                  3:       op = 5'h07;
                  default: op = 5'($urandom);
               endcase
               ir_scan(op, cap);
            end
            1, 2: begin
               rdata = $urandom;
               dr_scan($urandom_range(1, 40), {$urandom, $urandom}, 1'b0, dout);
            end
            default: begin
               rdata = $urandom;
               for (int k = 0; k < int'($urandom_range(1, 10)); k++)
                  tck_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d);
               to_rti();
            end
         endcase
      end

      check("wvalid_single_cycle", 32'(long_pulses), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/rt_jtag_tap_sampled.md
# rt_jtag_tap_sampled

JTAG test access port (TAP) responder for the RT-SS FPGA prototype. It receives the board-level JTAG pins (`jtag_tck_i`, `jtag_tms_i`, `jtag_trst_ni`, `jtag_td_i`) and drives `jtag_td_o`, i.e. it is the target end of the pin-level JTAG initiator used by the FPGA benches. TCK is oversampled on the system clock, so the whole block runs in one clock domain. It provides IDCODE, BYPASS and a 32-bit USER data register with a parallel read/write port into the RT-SS fabric.

## Interface

Parameters:
- `IrLength`, 5, instruction register width.
- `IdCode`, 32'h1000_0DB3, value captured by IDCODE; bit 0 must be 1.
- `UserDrWidth`, 32, USER data register width.
- `SyncStages`, 2, synchroniser depth for the JTAG inputs; minimum 2.

Ports:
- `clk_i`  in  1  system clock; at least 6× the TCK frequency.
- `rst_i`  in  1  reset, synchronous, active-high.
- `jtag_tck_i`  in  1  asynchronous TCK.
- `jtag_tms_i`  in  1  asynchronous TMS.
- `jtag_trst_ni`  in  1  asynchronous TRST, active-low; acted on after synchronisation.
- `jtag_td_i`  in  1  TDI.
- `jtag_td_o`  out  1  TDO.
- `jtag_td_oe_o`  out  1  TDO enable; high only in Shift-IR and Shift-DR.
- `user_rdata_i`  in  UserDrWidth  value loaded into the USER DR on Capture-DR.
- `user_wdata_o`  out  UserDrWidth  USER DR contents latched on Update-DR.
- `user_wvalid_o`  out  1  one-`clk_i` pulse when `user_wdata_o` updates.
- `tap_state_o`  out  4  current TAP state, for debug.

## Operation

- TCK, TMS, TDI and TRST each pass through `SyncStages` flops. A rising or falling TCK edge is detected from the last two synchronised samples and yields a one-cycle `tck_rise` or `tck_fall` strobe.
- The TAP FSM has the standard 16 IEEE 1149.1 states: TLR, RTI, Sel-DR, Cap-DR, Shift-DR, Exit1-DR, Pause-DR, Exit2-DR, Upd-DR, and the six matching IR states. It advances only on `tck_rise`, using the synchronised TMS sampled in that same cycle.
- Entering TLR (through the TMS path, `rst_i`, or synchronised TRST low) sets the IR to IDCODE.
- Opcodes: IDCODE = 5'h01, USER = 5'h10, BYPASS = 5'h1F. Every other opcode selects BYPASS.
- On `tck_rise` in these states:
  - Cap-IR loads the IR shift register with 5'b00001.
  - Shift-IR shifts TDI in at the MSB; the LSB leaves first.
  - Upd-IR copies the shift register into the IR.
  - Cap-DR loads the selected DR: `IdCode`, `user_rdata_i`, or a 1-bit 0 for BYPASS.
  - Shift-DR shifts the selected DR, LSB first, with TDI entering at the MSB.
  - Upd-DR with IR = USER latches the shift register into `user_wdata_o` and pulses `user_wvalid_o`.
- TDO changes only on `tck_fall`. It is loaded with the LSB of the active shift register when the state is Shift-IR or Shift-DR; otherwise it is 0. `jtag_td_oe_o` is registered on the same strobe.
- TRST low forces TLR on the next `clk_i` edge, regardless of TCK.

## Timing

- Reset values: `jtag_td_o` = 0, `jtag_td_oe_o` = 0, `user_wdata_o` = 0, `user_wvalid_o` = 0, `tap_state_o` = TLR, IR = IDCODE, all shift registers 0.
- Pin-to-strobe latency is `SyncStages` + 1 `clk_i` cycles.
- The FSM state and shift registers update in the cycle after `tck_rise`.
- `user_wvalid_o` is high for exactly one cycle, the cycle after the Upd-DR `tck_rise`.
- `jtag_td_o` is valid `SyncStages` + 2 cycles after the TCK falling pin edge.
- TCK high and low phases must each last at least 3 `clk_i` cycles. Shorter pulses may be dropped and are not detected as errors.
- If TRST low coincides with `tck_rise`, TRST wins: the state goes to TLR, no update or pulse occurs, and TDO stays 0.
- `rst_i` during a shift discards shift contents. No `user_wvalid_o` pulse is generated.
- A USER DR shift longer than `UserDrWidth` keeps only the last `UserDrWidth` bits.

## Structure

- Package `rt_jtag_pkg`:
  - `tap_state_e`, a 4-bit enum holding the 16 states.
  - `IR_IDCODE`, `IR_USER`, `IR_BYPASS` opcode constants.
  - `IrCaptureVal` = 5'b00001.
- Sub-module `rt_jtag_sync_edge`: synchroniser plus edge detector with `SyncStages` parameter. It outputs the synchronised level and the rise/fall strobes. One instance is used for TCK; TMS, TDI and TRST use its level output only.
- The top level contains the FSM, IR, DR multiplexer, TDO register and USER port logic.

## Test plan

- `rst_i` high 4 cycles, then low → `tap_state_o` = TLR, `jtag_td_oe_o` = 0, `user_wvalid_o` = 0; IR reads back IDCODE.
- From TLR go to Shift-DR and shift 32 bits → TDO serial stream, LSB first, equals 0x1000_0DB3; `jtag_td_oe_o` is 1 only during the shift.
- Load IR 5'h1F, then shift DR with TDI pattern 1,0,1,1 → TDO is 0,1,0,1, i.e. a 1-bit delay with the captured 0 first.
- Load IR 5'h10 with `user_rdata_i` = 0xCAFE_F00D, then shift in 0xDEAD_BEEF → TDO yields 0xCAFE_F00D; after Upd-DR, `user_wdata_o` = 0xDEAD_BEEF with a single-cycle `user_wvalid_o`.
- From Pause-DR, TMS = 1 for 5 TCK cycles → TLR and IR = IDCODE; an unknown IR 5'h07 then behaves as BYPASS.
- TRST low for 2 `clk_i` cycles in the middle of a USER Shift-DR → TLR within `SyncStages` + 1 cycles, no `user_wvalid_o` pulse, `user_wdata_o` unchanged.
